// File: rtl/rst_sequencer.sv
// Purpose : staged reset tree from PLL lock, board button and soft request.
// Latency : registered outputs; SyncStages+1 edges from PLL loss to reset asserted.
// Backpr. : none; sw_rst_req_i/cause_clr_i are single-cycle pulses, never stalled.
//
// Ports:
//   clk_sys        system clock (only clock of this block)
//   rst_sys        synchronous active-high reset of this block
//   pll_locked_i   PLL lock, asynchronous, synchronised here
//   ext_rst_ni     board reset button, active-low, asynchronous and bouncy
//   sw_rst_req_i   one-cycle soft reset request (synchronous)
//   cause_clr_i    clears the sticky cause vector (synchronous)
//   rst_dbg_no     debug-domain reset, active-low, untouched by soft reset
//   rst_periph_no  peripheral-domain reset, active-low
//   rst_core_no    core-domain reset, active-low, released CoreDelay after periph
//   cause_o        sticky cause: [2] soft, [1] button, [0] PLL
module rst_sequencer #(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 500000,
    parameter int HoldCycles     = 16,
    parameter int CoreDelay      = 8
) (
    input  logic       clk_sys,
    input  logic       rst_sys,
    input  logic       pll_locked_i,
    input  logic       ext_rst_ni,
    input  logic       sw_rst_req_i,
    input  logic       cause_clr_i,
    output logic       rst_dbg_no,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic [2:0] cause_o
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    localparam int DbW    = $clog2(DebounceCycles + 1);
    localparam int CntMax = (HoldCycles > CoreDelay) ? HoldCycles : CoreDelay;
    localparam int CntW   = $clog2(CntMax + 1);

    localparam logic [DbW-1:0]  DbLast   = DbW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] CoreLast = CntW'(CoreDelay - 1);

    typedef enum logic [2:0] {
        ST_HARD      = 3'd0,
        ST_SOFT      = 3'd1,
        ST_HOLD      = 3'd2,
        ST_CORE_WAIT = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // The lock chain resets to 0 so a freshly reset block always treats
    // the PLL as unlocked until proven otherwise; this is also why cause
    // bit0 is set after every rst_sys sequence.
    // ------------------------------------------------------------------
    logic [SyncStages-1:0] r_lock_sync;
    logic [SyncStages-1:0] r_ext_sync;
    logic                  w_locked_sync;
    logic                  w_btn_pressed_sync;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_lock_sync <= '0;
            r_ext_sync  <= '1;
        end else begin
            r_lock_sync <= {r_lock_sync[SyncStages-2:0], pll_locked_i};
            r_ext_sync  <= {r_ext_sync[SyncStages-2:0], ext_rst_ni};
        end
    end

    assign w_locked_sync      = r_lock_sync[SyncStages-1];
    assign w_btn_pressed_sync = ~r_ext_sync[SyncStages-1];

    // ------------------------------------------------------------------
    // Button debounce
    // The counter only runs while the synchronised level disagrees with
    // the debounced level; any agreement (a bounce) restarts the count.
    // The flip happens on the edge that observes the terminal count, so
    // a new level must persist for exactly DebounceCycles edges.
    // ------------------------------------------------------------------
    logic           r_btn_db;
    logic [DbW-1:0] r_db_cnt;
    logic           w_ext_act;
    logic           w_hard;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else if (w_btn_pressed_sync != r_btn_db) begin
            if (r_db_cnt == DbLast) begin
                r_btn_db <= w_btn_pressed_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DbW'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_ext_act = r_btn_db;
    assign w_hard    = ~w_locked_sync | w_ext_act;

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            r_rst_dbg_n;
    logic            r_rst_periph_n;
    logic            r_rst_core_n;
    logic            w_rst_dbg_n_nxt;
    logic            w_rst_periph_n_nxt;
    logic            w_rst_core_n_nxt;
    logic [2:0]      r_cause;
    logic [2:0]      w_cause_nxt;
    logic [2:0]      w_cause_set;

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state        <= ST_HARD;
            r_cnt          <= '0;
            r_rst_dbg_n    <= 1'b0;
            r_rst_periph_n <= 1'b0;
            r_rst_core_n   <= 1'b0;
            r_cause        <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rst_dbg_n    <= w_rst_dbg_n_nxt;
            r_rst_periph_n <= w_rst_periph_n_nxt;
            r_rst_core_n   <= w_rst_core_n_nxt;
            r_cause        <= w_cause_nxt;
        end
    end

    // Soft request is ignored while a hard reset is in force (HARD state);
    // when both fire together the hard path wins but both causes are kept.
    always_comb begin
        w_cause_set    = '0;
        w_cause_set[0] = ~w_locked_sync;
        w_cause_set[1] = w_ext_act;
        w_cause_set[2] = sw_rst_req_i & (r_state != ST_HARD);
        // Set wins over clear: clear first, then OR in this cycle's causes.
        w_cause_nxt    = (cause_clr_i ? 3'b000 : r_cause) | w_cause_set;
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_rst_dbg_n_nxt    = r_rst_dbg_n;
        w_rst_periph_n_nxt = r_rst_periph_n;
        w_rst_core_n_nxt   = r_rst_core_n;

        if (w_hard) begin
            // Any hard source restarts the whole sequence from scratch,
            // including from mid-HOLD or mid-CORE_WAIT.
            w_state_nxt        = ST_HARD;
            w_cnt_nxt          = '0;
            w_rst_dbg_n_nxt    = 1'b0;
            w_rst_periph_n_nxt = 1'b0;
            w_rst_core_n_nxt   = 1'b0;
        end else if (sw_rst_req_i && (r_state != ST_HARD)) begin
            // Soft reset leaves the debug domain alone so a debugger
            // stays attached across a software-initiated reset.
            w_state_nxt        = ST_SOFT;
            w_cnt_nxt          = '0;
            w_rst_periph_n_nxt = 1'b0;
            w_rst_core_n_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_HARD, ST_SOFT: begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
                ST_HOLD: begin
                    if (r_cnt == HoldLast) begin
                        w_state_nxt        = ST_CORE_WAIT;
                        w_cnt_nxt          = '0;
                        w_rst_dbg_n_nxt    = 1'b1;
                        w_rst_periph_n_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end
                ST_CORE_WAIT: begin
                    if (r_cnt == CoreLast) begin
                        w_state_nxt      = ST_RUN;
                        w_cnt_nxt        = '0;
                        w_rst_core_n_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end
                ST_RUN: begin
                    w_rst_dbg_n_nxt    = 1'b1;
                    w_rst_periph_n_nxt = 1'b1;
                    w_rst_core_n_nxt   = 1'b1;
                end
                default: begin
                    // Unused encodings fall back into a full reset.
                    w_state_nxt        = ST_HARD;
                    w_cnt_nxt          = '0;
                    w_rst_dbg_n_nxt    = 1'b0;
                    w_rst_periph_n_nxt = 1'b0;
                    w_rst_core_n_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign rst_dbg_no    = r_rst_dbg_n;
    assign rst_periph_no = r_rst_periph_n;
    assign rst_core_no   = r_rst_core_n;
    assign cause_o       = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

    localparam int SyncStages     = 2;
    localparam int DebounceCycles = 100;
    localparam int HoldCycles     = 16;
    localparam int CoreDelay      = 8;

    logic       clk_sys = 1'b0;
    logic       rst_sys;
    logic       pll_locked_i;
    logic       ext_rst_ni;
    logic       sw_rst_req_i;
    logic       cause_clr_i;
    logic       rst_dbg_no;
    logic       rst_periph_no;
    logic       rst_core_no;
    logic [2:0] cause_o;

    rst_sequencer #(
        .SyncStages    (SyncStages),
        .DebounceCycles(DebounceCycles),
        .HoldCycles    (HoldCycles),
        .CoreDelay     (CoreDelay)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys      (rst_sys),
        .pll_locked_i (pll_locked_i),
        .ext_rst_ni   (ext_rst_ni),
        .sw_rst_req_i (sw_rst_req_i),
        .cause_clr_i  (cause_clr_i),
        .rst_dbg_no   (rst_dbg_no),
        .rst_periph_no(rst_periph_no),
        .rst_core_no  (rst_core_no),
        .cause_o      (cause_o)
    );

    always #5 clk_sys = ~clk_sys;

    // One record = inputs held for one clock edge, plus the outputs
    // required right after that edge: {dbg, periph, core, cause[2:0]}.
    typedef struct {
        logic       rst;
        logic       pll;
        logic       ext;
        logic       sw;
        logic       clr;
        logic [5:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];   // stimulus table for the current scenario
    vec_t sb[$];     // scoreboard: expectations awaiting the DUT edge
    vec_t cv;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] ex(input logic d, input logic p, input logic c,
                                      input logic [2:0] cause);
        return {d, p, c, cause};
    endfunction

    function automatic void add(input logic rst, input logic pll, input logic ext,
                                input logic sw, input logic clr,
                                input logic [5:0] exp, input string tag);
        vec_t v;
        v.rst = rst; v.pll = pll; v.ext = ext; v.sw = sw; v.clr = clr;
        v.exp = exp; v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Driver: applies the table one record per cycle on the falling edge
    // and pushes the expectation into the scoreboard.
    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_sys);
            rst_sys      = vecs[i].rst;
            pll_locked_i = vecs[i].pll;
            ext_rst_ni   = vecs[i].ext;
            sw_rst_req_i = vecs[i].sw;
            cause_clr_i  = vecs[i].clr;
            sb.push_back(vecs[i]);
        end
        vecs.delete();
    endtask

    // Checker: 1 time unit after each rising edge compare against the
    // oldest pending expectation.
    always @(posedge clk_sys) begin
        #1;
        if (sb.size() != 0) begin
            cv = sb.pop_front();
            checks++;
            if ({rst_dbg_no, rst_periph_no, rst_core_no, cause_o} !== cv.exp) begin
                errors++;
                $display("FAIL %s: got dbg/per/core/cause=%b required %b", cv.tag,
                         {rst_dbg_no, rst_periph_no, rst_core_no, cause_o}, cv.exp);
            end
        end
    end

    // Power-on style release: 4 reset edges, then edge 1..30.
    // PLL sync becomes valid at edge 3, HOLD runs edges 4..19,
    // periph/dbg release at 19, core at 27; cause bit0 from edge 1.
    task automatic por(input string s);
        for (int i = 1; i <= 4; i++)
            add(1, 1, 1, 0, 0, ex(0, 0, 0, 3'b000), $sformatf("%s rst%0d", s, i));
        for (int e = 1; e <= 30; e++)
            add(0, 1, 1, 0, 0, ex(e >= 19, e >= 19, e >= 27, 3'b001),
                $sformatf("%s e%0d", s, e));
        run_vecs();
    endtask

    initial begin
        rst_sys = 1'b1; pll_locked_i = 1'b1; ext_rst_ni = 1'b1;
        sw_rst_req_i = 1'b0; cause_clr_i = 1'b0;

        // 1. Power-on release
        por("s1");

        // 2. Soft reset from RUN: dbg stays up, SOFT->HOLD next edge,
        //    periph 16 edges after that (k=17), core 8 later (k=25).
        add(0, 1, 1, 1, 0, ex(1, 0, 0, 3'b101), "s2 swpulse");
        for (int k = 1; k <= 30; k++)
            add(0, 1, 1, 0, 0, ex(1, k >= 17, k >= 25, 3'b101), $sformatf("s2 k%0d", k));
        add(0, 1, 1, 0, 1, ex(1, 1, 1, 3'b000), "s2 clear");
        run_vecs();

        // 3. Button debounce: 50 pressed, 1 released glitch, then pressed.
        //    Resets drop SyncStages+DebounceCycles+1 = 103 edges after the glitch.
        for (int k = 1; k <= 50; k++)
            add(0, 1, 0, 0, 0, ex(1, 1, 1, 3'b000), $sformatf("s3 pre%0d", k));
        add(0, 1, 1, 0, 0, ex(1, 1, 1, 3'b000), "s3 glitch");
        for (int j = 1; j <= 150; j++)
            add(0, 1, 0, 0, 0, (j >= SyncStages + DebounceCycles + 1) ?
                ex(0, 0, 0, 3'b010) : ex(1, 1, 1, 3'b000), $sformatf("s3 j%0d", j));
        // Release: debounced flips at 102, HOLD from 103, periph 119, core 127.
        for (int r = 1; r <= 130; r++)
            add(0, 1, 1, 0, 0, ex(r >= 119, r >= 119, r >= 127, 3'b010),
                $sformatf("s3 rel%0d", r));
        add(0, 1, 1, 0, 1, ex(1, 1, 1, 3'b000), "s3 clear");
        run_vecs();

        // 4. PLL loss in CORE_WAIT: soft reset to get there, drop lock for
        //    edges 19..21; resets drop at 21, relock seen at 24, periph 40, core 48.
        add(0, 1, 1, 1, 0, ex(1, 0, 0, 3'b100), "s4 swpulse");
        for (int k = 1; k <= 18; k++)
            add(0, 1, 1, 0, 0, ex(1, k >= 17, 0, 3'b100), $sformatf("s4 k%0d", k));
        add(0, 0, 1, 0, 0, ex(1, 1, 0, 3'b100), "s4 k19");
        add(0, 0, 1, 0, 0, ex(1, 1, 0, 3'b100), "s4 k20");
        add(0, 0, 1, 0, 0, ex(0, 0, 0, 3'b101), "s4 k21");
        for (int k = 22; k <= 55; k++)
            add(0, 1, 1, 0, 0, ex(k >= 40, k >= 40, k >= 48, 3'b101), $sformatf("s4 k%0d", k));
        add(0, 1, 1, 0, 1, ex(1, 1, 1, 3'b000), "s4 clear");
        run_vecs();

        // 5a. Soft request on the same edge the PLL loss resolves: HARD wins.
        add(0, 0, 1, 0, 0, ex(1, 1, 1, 3'b000), "s5 k1");
        add(0, 0, 1, 0, 0, ex(1, 1, 1, 3'b000), "s5 k2");
        add(0, 1, 1, 1, 0, ex(0, 0, 0, 3'b101), "s5 both");
        for (int k = 4; k <= 30; k++)
            add(0, 1, 1, 0, 0, ex(k >= 21, k >= 21, k >= 29, 3'b101), $sformatf("s5 k%0d", k));
        // 5b. Clear together with a new soft cause: bit2 kept, bit0 cleared.
        add(0, 1, 1, 1, 1, ex(1, 0, 0, 3'b100), "s5 setclr");
        for (int k = 1; k <= 25; k++)
            add(0, 1, 1, 0, 0, ex(1, k >= 17, k >= 25, 3'b100), $sformatf("s5b k%0d", k));
        run_vecs();

        // 6. rst_sys while in RUN: everything (cause too) zero next edge,
        //    then the power-on timing repeats.
        por("s6");

        @(posedge clk_sys);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
